// File: rtl/aes_pkg.sv
// Shared AES datapath types for the round stages.
// Provides byte/state typedefs, the state byte count and the SubBytes FSM enum.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sb_fsm_e;

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Valid/ready bundle around the SubBytes stage: input side from AddRoundKey,
// output side to ShiftRows. slave = the stage, master = its neighbours.
interface sub_bytes_iter_if;
    import aes_pkg::*;

    logic   valid_i;
    logic   ready_o;
    logic   inv_i;
    state_t state_i;
    logic   valid_o;
    logic   ready_i;
    state_t state_o;

    modport slave (
        input  valid_i,
        input  inv_i,
        input  state_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output state_o
    );

    modport master (
        output valid_i,
        output inv_i,
        output state_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  state_o
    );

endinterface

// File: rtl/sub_bytes_iter_inv_s_box.sv
// AES inverse S-box, combinational; built only when SUB_BYTES_INV_EN is set.
// Ports: din (byte in), dout (inverse-substituted byte out).
`ifdef SUB_BYTES_INV_EN
module inv_s_box
    import aes_pkg::*;
(
    input  byte_t din,
    output byte_t dout
);

    localparam byte_t TBL [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign dout = TBL[din];

endmodule
`endif

// File: rtl/sub_bytes_iter_s_box.sv
// AES forward S-box, purely combinational table lookup.
// Ports: din (byte in), dout (substituted byte out).
module s_box
    import aes_pkg::*;
(
    input  byte_t din,
    output byte_t dout
);

    localparam byte_t TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = TBL[din];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-boxes fold 16 bytes over 16/LANES beats.
// Ports: clk, rst_n (async low), en (global stall), bus (slave side of
// sub_bytes_iter_if: valid_i/ready_o/inv_i/state_i in, valid_o/ready_i/state_o
// out). Define SUB_BYTES_INV_EN to add per-lane inverse S-boxes (decrypt).
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    sub_bytes_iter_if.slave bus
);

    localparam int ROUNDS = NUM_BYTES / LANES;
    localparam int BW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [BW-1:0] LAST = BW'(ROUNDS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_fsm_e       fsm;
    logic [BW-1:0] beat;
    state_t        work;
    state_t        work_nxt;
    logic          valid_q;
    logic          ready;
    logic          accept;
    logic [3:0]    base;
    byte_t         lane_in  [LANES];
    byte_t         lane_out [LANES];

    // rst_n gates ready so nothing looks acceptable while reset is held.
    assign ready  = rst_n && en &&
                    (fsm == IDLE || (fsm == DONE && bus.ready_i));
    assign accept = bus.valid_i && ready;

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.state_o = work;

    // First byte handled in this beat.
    assign base = 4'(beat * LANES);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = work[{base + 4'(l), 3'b000} +: 8];
        end
    end

    always_comb begin
        work_nxt = work;
        for (int l = 0; l < LANES; l++) begin
            work_nxt[{base + 4'(l), 3'b000} +: 8] = lane_out[l];
        end
    end

`ifdef SUB_BYTES_INV_EN
    logic inv_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (accept) begin
            inv_q <= bus.inv_i;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = bus.inv_i;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        byte_t fwd;

        s_box u_s_box (
            .din  (lane_in[l]),
            .dout (fwd)
        );

`ifdef SUB_BYTES_INV_EN
        byte_t rev;

        inv_s_box u_inv_s_box (
            .din  (lane_in[l]),
            .dout (rev)
        );

        assign lane_out[l] = inv_q ? rev : fwd;
`else
        assign lane_out[l] = fwd;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= IDLE;
            beat    <= '0;
            work    <= '0;
            valid_q <= 1'b0;
        end else if (en) begin
            unique case (fsm)
                IDLE: begin
                    if (accept) begin
                        work <= bus.state_i;
                        beat <= '0;
                        fsm  <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_nxt;
                    if (beat == LAST) begin
                        beat    <= '0;
                        fsm     <= DONE;
                        valid_q <= 1'b1;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                DONE: begin
                    // Output transfer; a new block may load on the same edge.
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        if (accept) begin
                            work <= bus.state_i;
                            beat <= '0;
                            fsm  <= BUSY;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: five instances (LANES 16/4/2/1/8)
// exercised for latency, results, back-pressure, stall, reset and streaming.
module tb_sub_bytes_iter;
    import aes_pkg::*;

    localparam int ND = 5;
    localparam int LT [ND] = '{16, 4, 2, 1, 8};

    localparam state_t V    = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam state_t VE   = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam state_t PART = 128'h0f0e0d0c0b0a090807066bf27b777c63;
    localparam state_t S63  = {16{8'h63}};
    localparam state_t SFB  = {16{8'hfb}};
    localparam state_t S01  = {16{8'h01}};
    localparam state_t S7C  = {16{8'h7c}};
    localparam state_t Z    = '0;

    logic clk = 1'b0;
    logic rst_n;
    logic en      [ND];
    logic valid_i [ND];
    logic inv_i   [ND];
    logic ready_i [ND];
    state_t state_i [ND];
    wire        ready_o [ND];
    wire        valid_o [ND];
    wire [127:0] state_o [ND];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        sub_bytes_iter_if u_if ();

        assign u_if.valid_i = valid_i[g];
        assign u_if.inv_i   = inv_i[g];
        assign u_if.state_i = state_i[g];
        assign u_if.ready_i = ready_i[g];
        assign ready_o[g]   = u_if.ready_o;
        assign valid_o[g]   = u_if.valid_o;
        assign state_o[g]   = u_if.state_o;

        sub_bytes_iter #(.LANES(LT[g])) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en[g]),
            .bus   (u_if.slave)
        );
    end

    // Presents one block and returns #1 after its accept edge.
    task automatic send(input int d, input state_t s, input logic inv);
        int k = 0;
        state_i[d] = s;
        inv_i[d]   = inv;
        valid_i[d] = 1'b1;
        #1;
        while (!ready_o[d] && k < 40) begin
            @(posedge clk); #1; k++;
        end
        nvec++;
        if (ready_o[d] !== 1'b1) begin
            nerr++;
            $display("FAIL send_ready d%0d: got %b want 1", d, ready_o[d]);
        end
        @(posedge clk); #1;
        valid_i[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int e);
        e = 0;
        while (valid_o[d] !== 1'b1 && e < 40) begin
            @(posedge clk); #1; e++;
        end
    endtask

    task automatic drain(input int d);
        ready_i[d] = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #12;
        for (int d = 0; d < ND; d++) begin
            nvec += 3;
            if (valid_o[d] !== 1'b0) begin
                nerr++;
                $display("FAIL rst_valid d%0d: got %b want 0", d, valid_o[d]);
            end
            if (state_o[d] !== Z) begin
                nerr++;
                $display("FAIL rst_state d%0d: got %h want 0", d, state_o[d]);
            end
            if (ready_o[d] !== 1'b0) begin
                nerr++;
                $display("FAIL rst_ready d%0d: got %b want 0", d, ready_o[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++) begin
            nvec++;
            if (ready_o[d] !== 1'b1) begin
                nerr++;
                $display("FAIL idle_ready d%0d: got %b want 1", d, ready_o[d]);
            end
        end
    endtask

    task automatic test_lanes;
        int e;
        for (int d = 0; d < 4; d++) begin
            send(d, V, 1'b0);
            inv_i[d] = 1'b1;
            wait_valid(d, e);
            nvec += 2;
            if (e != 16 / LT[d]) begin
                nerr++;
                $display("FAIL latency L%0d: got %0d want %0d",
                         LT[d], e, 16 / LT[d]);
            end
            if (state_o[d] !== VE) begin
                nerr++;
                $display("FAIL result L%0d: got %h want %h",
                         LT[d], state_o[d], VE);
            end
            drain(d);
            inv_i[d] = 1'b0;
            nvec++;
            if (valid_o[d] !== 1'b0) begin
                nerr++;
                $display("FAIL valid_drop L%0d: got %b want 0",
                         LT[d], valid_o[d]);
            end
        end
    endtask

    task automatic test_zero;
        int e;
        send(1, Z, 1'b0);
        wait_valid(1, e);
        nvec++;
        if (state_o[1] !== S63) begin
            nerr++;
            $display("FAIL zero_fwd: got %h want %h", state_o[1], S63);
        end
        drain(1);
`ifdef SUB_BYTES_INV_EN
        send(1, S63, 1'b1);
        wait_valid(1, e);
        nvec++;
        if (state_o[1] !== Z) begin
            nerr++;
            $display("FAIL inv_63: got %h want %h", state_o[1], Z);
        end
        drain(1);
        send(1, VE, 1'b1);
        wait_valid(1, e);
        nvec++;
        if (state_o[1] !== V) begin
            nerr++;
            $display("FAIL inv_vec: got %h want %h", state_o[1], V);
        end
        drain(1);
`else
        send(1, V, 1'b1);
        wait_valid(1, e);
        nvec++;
        if (state_o[1] !== VE) begin
            nerr++;
            $display("FAIL inv_ignored: got %h want %h", state_o[1], VE);
        end
        drain(1);
`endif
    endtask

    task automatic test_backpressure;
        int e;
        ready_i[1] = 1'b0;
        send(1, V, 1'b0);
        wait_valid(1, e);
        nvec++;
        if (e != 4) begin
            nerr++;
            $display("FAIL bp_latency: got %0d want 4", e);
        end
        state_i[1] = Z;
        valid_i[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nvec += 3;
            if (valid_o[1] !== 1'b1) begin
                nerr++;
                $display("FAIL bp_valid c%0d: got %b want 1", c, valid_o[1]);
            end
            if (state_o[1] !== VE) begin
                nerr++;
                $display("FAIL bp_state c%0d: got %h want %h",
                         c, state_o[1], VE);
            end
            if (ready_o[1] !== 1'b0) begin
                nerr++;
                $display("FAIL bp_ready c%0d: got %b want 0", c, ready_o[1]);
            end
        end
        ready_i[1] = 1'b1;
        #1;
        nvec++;
        if (ready_o[1] !== 1'b1) begin
            nerr++;
            $display("FAIL bp_release_ready: got %b want 1", ready_o[1]);
        end
        @(posedge clk); #1;
        valid_i[1] = 1'b0;
        nvec++;
        if (valid_o[1] !== 1'b0) begin
            nerr++;
            $display("FAIL bp_xfer: got %b want 0", valid_o[1]);
        end
        wait_valid(1, e);
        nvec += 2;
        if (e != 4) begin
            nerr++;
            $display("FAIL bp_next_latency: got %0d want 4", e);
        end
        if (state_o[1] !== S63) begin
            nerr++;
            $display("FAIL bp_next_state: got %h want %h", state_o[1], S63);
        end
        drain(1);
    endtask

    task automatic test_stall;
        int e;
        send(2, V, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        nvec++;
        if (state_o[2] !== PART) begin
            nerr++;
            $display("FAIL stall_part: got %h want %h", state_o[2], PART);
        end
        en[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            nvec += 3;
            if (state_o[2] !== PART) begin
                nerr++;
                $display("FAIL stall_hold c%0d: got %h want %h",
                         c, state_o[2], PART);
            end
            if (ready_o[2] !== 1'b0) begin
                nerr++;
                $display("FAIL stall_ready c%0d: got %b want 0", c, ready_o[2]);
            end
            if (valid_o[2] !== 1'b0) begin
                nerr++;
                $display("FAIL stall_valid c%0d: got %b want 0", c, valid_o[2]);
            end
        end
        en[2] = 1'b1;
        wait_valid(2, e);
        nvec += 2;
        if (e + 6 != 11) begin
            nerr++;
            $display("FAIL stall_latency: got %0d want 11", e + 6);
        end
        if (state_o[2] !== VE) begin
            nerr++;
            $display("FAIL stall_result: got %h want %h", state_o[2], VE);
        end
        drain(2);
    endtask

    task automatic test_reset_mid;
        int e;
        send(1, V, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        nvec += 3;
        if (valid_o[1] !== 1'b0) begin
            nerr++;
            $display("FAIL mid_rst_valid: got %b want 0", valid_o[1]);
        end
        if (state_o[1] !== Z) begin
            nerr++;
            $display("FAIL mid_rst_state: got %h want 0", state_o[1]);
        end
        if (ready_o[1] !== 1'b0) begin
            nerr++;
            $display("FAIL mid_rst_ready: got %b want 0", ready_o[1]);
        end
        #2;
        rst_n = 1'b1;
        #1;
        nvec++;
        if (ready_o[1] !== 1'b1) begin
            nerr++;
            $display("FAIL mid_rel_ready: got %b want 1", ready_o[1]);
        end
        repeat (6) begin
            @(posedge clk); #1;
        end
        nvec++;
        if (valid_o[1] !== 1'b0) begin
            nerr++;
            $display("FAIL mid_ghost: got %b want 0", valid_o[1]);
        end
        send(1, Z, 1'b0);
        wait_valid(1, e);
        nvec += 2;
        if (e != 4) begin
            nerr++;
            $display("FAIL mid_next_latency: got %0d want 4", e);
        end
        if (state_o[1] !== S63) begin
            nerr++;
            $display("FAIL mid_next_state: got %h want %h", state_o[1], S63);
        end
        drain(1);
    endtask

    task automatic test_back_to_back;
        state_t blk [4];
        state_t exp [4];
        state_t so;
        int k = 0;
        int j = 0;
        int cyc = 0;
        int last = 0;
        logic acc;
        logic xf;
        blk = '{V, Z, S63, S01};
        exp = '{VE, S63, SFB, S7C};
        ready_i[4] = 1'b1;
        state_i[4] = blk[0];
        valid_i[4] = 1'b1;
        while (j < 4 && cyc < 60) begin
            acc = valid_i[4] && ready_o[4];
            xf  = valid_o[4] && ready_i[4];
            so  = state_o[4];
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                k++;
                if (k < 4) state_i[4] = blk[k];
                else valid_i[4] = 1'b0;
            end
            if (xf) begin
                nvec++;
                if (so !== exp[j]) begin
                    nerr++;
                    $display("FAIL b2b_data%0d: got %h want %h", j, so, exp[j]);
                end
                if (j > 0) begin
                    nvec++;
                    if (cyc - last != 3) begin
                        nerr++;
                        $display("FAIL b2b_gap%0d: got %0d want 3",
                                 j, cyc - last);
                    end
                end
                last = cyc;
                j++;
            end
        end
        valid_i[4] = 1'b0;
        nvec++;
        if (j != 4) begin
            nerr++;
            $display("FAIL b2b_count: got %0d want 4", j);
        end
        repeat (6) begin
            @(posedge clk); #1;
        end
        nvec++;
        if (valid_o[4] !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_dup: got %b want 0", valid_o[4]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            en[d]      = 1'b1;
            valid_i[d] = 1'b0;
            inv_i[d]   = 1'b0;
            ready_i[d] = 1'b1;
            state_i[d] = '0;
        end
        test_reset;
        test_lanes;
        test_zero;
        test_backpressure;
        test_stall;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Parametrised, iterative AES SubBytes stage with a full valid/ready handshake.
- Folds the 16-byte substitution over 16/LANES cycles using LANES S-box instances, trading latency for area.
- Sits between the AddRoundKey and ShiftRows stages of the round datapath.
- Keeps the global `en` stall input. Adds output back-pressure and an optional inverse (decrypt) mode.

Parameters:
- LANES, 16, number of S-box instances (bytes substituted per cycle). Legal values: 1, 2, 4, 8, 16. Any other value triggers an elaboration-time $error.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global stall. When 0, every register holds and no handshake completes.
- valid_i  input  1  input state valid.
- ready_o  output  1  block can accept an input this cycle.
- inv_i  input  1  1 = inverse S-box. Sampled on the accept edge.
- state_i  input  128  input state; byte k = state_i[8k+7:8k].
- valid_o  output  1  output state valid.
- ready_i  input  1  downstream can accept.
- state_o  output  128  substituted state; byte order same as state_i.

Behaviour:
- Reset (async, rst_n=0):
  - FSM state = IDLE, beat counter = 0, work register = 0, inv latch = 0.
  - valid_o = 0, state_o = 0, ready_o = 0 while reset is asserted.
  - Reset mid-operation discards the in-flight block. No output appears for it.
- ROUNDS = 16/LANES. Beat counter width is clog2(ROUNDS), minimum 1 bit.
- ready_o = en && (fsm==IDLE || (fsm==DONE && ready_i)). Combinational.
- Input accept: valid_i && ready_o on a rising edge.
  - work register <= state_i (raw), inv latch <= inv_i, beat <= 0, fsm -> BUSY.
- BUSY, per en=1 edge:
  - Bytes [beat*LANES, beat*LANES+LANES-1] of the work register are replaced by their S-box (or inverse S-box) values.
  - All other bytes hold.
  - beat increments. On beat==ROUNDS-1 the fsm moves to DONE and beat wraps to 0.
- DONE:
  - valid_o = 1. state_o holds until valid_o && ready_i && en.
  - If a new accept occurs on the same edge, go to BUSY. Otherwise go to IDLE.
- valid_o is registered: 1 exactly in DONE.
- state_o always equals the work register. It is meaningful only when valid_o=1.
- Latency: valid_o rises ROUNDS edges after the accept edge. LANES=16 gives 1 cycle, matching the existing stage.
- Throughput with back-to-back traffic and ready_i=1: one block every ROUNDS+1 cycles (LANES=16 gives 2).
- Back-pressure: ready_i=0 in DONE holds valid_o and state_o stable indefinitely, with no new accept.
- en=0 in any state: FSM, beat, work register and valid_o freeze. ready_o=0.
- valid_i is ignored when ready_o=0. The upstream must hold data until accepted.
- inv_i changing during BUSY has no effect.

Optional Feature:
- Macro SUB_BYTES_INV_EN.
- Defined:
  - Each lane instantiates s_box and inv_s_box.
  - The latched inv bit selects the inverse output.
- Undefined:
  - Only s_box is instantiated.
  - inv_i is ignored and the inv latch is removed.
  - Encryption-only behaviour; area is reduced.

Decomposition:
- aes_pkg holds:
  - typedef byte_t (logic [7:0])
  - typedef state_t (logic [127:0])
  - localparam NUM_BYTES = 16
  - enum sb_fsm_e {IDLE, BUSY, DONE}
- Sub-modules:
  - The existing s_box.
  - New combinational inv_s_box (8-bit in/out), compiled only under SUB_BYTES_INV_EN.
- The lane mux/demux stays inline.

Test Plan:
- All four LANES values below use the same stimulus:
  - Stimulus: state_i=128'h0f0e0d0c0b0a09080706050403020100, LANES=16 and LANES=4.
  - Response: state_o=128'h76abd7fe2b670130c56f6bf27b777c63.
  - Timing: valid_o rises 1 and 4 edges after accept respectively.
  - LANES=1 and LANES=2 give the same result after 16 and 8 edges.
- All-zero state_i, inv_i=0 -> state_o=all 0x63. With SUB_BYTES_INV_EN, all-0x63 input with inv_i=1 -> all 0x00.
- ready_i=0 for 5 cycles after valid_o rises, LANES=4 -> valid_o and state_o stable, ready_o=0. ready_i=1 with valid_i=1 -> next block accepted on the same edge as the output transfer.
- en=0 for 3 cycles mid-BUSY (LANES=2, beat=3) -> work register and beat frozen. Final result is unchanged and valid_o arrives 3 cycles later than the nominal 8 edges.
- rst_n pulsed low mid-BUSY -> valid_o=0 and state_o=0 immediately (asynchronously). After release, ready_o=1 (en=1) and the next block completes normally.
- Back-to-back stream of 4 blocks with ready_i=1, LANES=8 -> one output every 3 cycles, in order, with no drop or duplicate.
